sim_tape_dev: RTL and testbench

SIM_TAPE_DEV -- requirements
Module: sim_tape_dev

---
 rtl/sim_dev_pkg.sv | 20 ++
 rtl/sim_dev_mem.sv | 33 +++
 rtl/sim_tape_dev.sv | 182 ++++++++++++++++++
 tb/tb_sim_tape_dev.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_dev_pkg.sv
// Shared definitions for the simulated paper-tape reader / punch device.
// Holds the 5-bit code width and the reader and punch state encodings.
package sim_dev_pkg;

    localparam int CODE_W = 5;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_PRESENT,
        RD_GAP,
        RD_DONE
    } rd_state_e;

    typedef enum logic [1:0] {
        PU_WAIT,
        PU_DELAY,
        PU_ACK
    } pu_state_e;

endpackage

// File: rtl/sim_dev_mem.sv
// Simple code memory: one write port, one registered read port.
// Ports:
//   clk, resetn   clock / async active-low reset (read register only)
//   we, waddr, wdata   write port
//   raddr, rdata       read port, rdata valid one cycle after raddr
// The storage array is deliberately not reset so tape/capture contents
// survive a device reset.
module sim_dev_mem #(
    parameter  int DEPTH = 64,
    parameter  int W     = 5,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rdata <= '0;
        else         rdata <= mem[raddr];
    end

endmodule

// File: rtl/sim_tape_dev.sv
// Simulated paper-tape device: a reader that streams a preloaded tape to
// the SoC over a val/rdy handshake, and a punch that acknowledges codes
// from the SoC after a programmable delay and captures them for readback.
// Ports:
//   clk, resetn                      clock, async active-low reset
//   ld_we/ld_addr/ld_data            tape memory load (ignored while busy)
//   ld_len, tape_start               tape length, start a read pass
//   dev_input_val/data/rdy           reader -> SoC stream
//   dev_output_rdy/data/ack          SoC -> punch handshake
//   rd_addr, rd_data                 capture buffer readback (1-cycle latency)
//   punch_count, punch_ovf           captured codes, sticky overflow
//   reader_busy, reader_done         reader status
module sim_tape_dev
    import sim_dev_pkg::*;
#(
    parameter  int IN_DEPTH  = 64,
    parameter  int OUT_DEPTH = 64,
    parameter  int ACK_DELAY = 2,
    parameter  int IN_GAP    = 1,
    localparam int IAW       = $clog2(IN_DEPTH),
    localparam int OAW       = $clog2(OUT_DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ld_we,
    input  logic [IAW-1:0]    ld_addr,
    input  logic [CODE_W-1:0] ld_data,
    input  logic [IAW:0]      ld_len,
    input  logic              tape_start,
    output logic              dev_input_val,
    output logic [CODE_W-1:0] dev_input_data,
    input  logic              dev_input_rdy,
    input  logic              dev_output_rdy,
    input  logic [CODE_W-1:0] dev_output_data,
    output logic              dev_output_ack,
    input  logic [OAW-1:0]    rd_addr,
    output logic [CODE_W-1:0] rd_data,
    output logic [OAW:0]      punch_count,
    output logic              reader_busy,
    output logic              reader_done,
    output logic              punch_ovf
);

    localparam logic [3:0] GAP_LOAD = 4'(IN_GAP > 0 ? IN_GAP - 1 : 0);
    localparam logic [3:0] DLY_LOAD = 4'(ACK_DELAY > 0 ? ACK_DELAY - 1 : 0);

    // ---------------- reader ----------------
    rd_state_e         rd_state, rd_state_nxt;
    logic [IAW-1:0]    ptr, ptr_nxt;
    logic [IAW:0]      len_q, len_nxt;
    logic [3:0]        gap_cnt, gap_cnt_nxt;
    logic [CODE_W-1:0] tape_q;
    logic              xfer;

    always_comb begin
        rd_state_nxt = rd_state;
        ptr_nxt      = ptr;
        len_nxt      = len_q;
        gap_cnt_nxt  = gap_cnt;
        xfer         = (rd_state == RD_PRESENT) && dev_input_rdy;
        unique case (rd_state)
            RD_IDLE, RD_DONE: begin
                if (tape_start) begin
                    len_nxt      = ld_len;
                    ptr_nxt      = '0;
                    rd_state_nxt = (ld_len == '0) ? RD_DONE : RD_PRESENT;
                end
            end
            RD_PRESENT: begin
                if (xfer) begin
                    if (({1'b0, ptr} + (IAW+1)'(1)) == len_q) begin
                        rd_state_nxt = RD_DONE;
                    end else begin
                        ptr_nxt = ptr + IAW'(1);
                        if (IN_GAP != 0) begin
                            rd_state_nxt = RD_GAP;
                            gap_cnt_nxt  = GAP_LOAD;
                        end
                    end
                end
            end
            RD_GAP: begin
                if (gap_cnt == '0) rd_state_nxt = RD_PRESENT;
                else               gap_cnt_nxt  = gap_cnt - 4'd1;
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state <= RD_IDLE;
            ptr      <= '0;
            len_q    <= '0;
            gap_cnt  <= '0;
        end else begin
            rd_state <= rd_state_nxt;
            ptr      <= ptr_nxt;
            len_q    <= len_nxt;
            gap_cnt  <= gap_cnt_nxt;
        end
    end

    assign dev_input_val  = (rd_state == RD_PRESENT);
    assign reader_busy    = (rd_state == RD_PRESENT) || (rd_state == RD_GAP);
    assign reader_done    = (rd_state == RD_DONE);
    // Read address follows the next pointer so the registered read data
    // lines up with the PRESENT cycle that offers it; writes are blocked
    // while busy, so the word stays stable until it is taken.
    assign dev_input_data = dev_input_val ? tape_q : '0;

    sim_dev_mem #(.DEPTH(IN_DEPTH), .W(CODE_W)) u_tape (
        .clk    (clk),
        .resetn (resetn),
        .we     (ld_we && !reader_busy),
        .waddr  (ld_addr),
        .wdata  (ld_data),
        .raddr  (ptr_nxt),
        .rdata  (tape_q)
    );

    // ---------------- punch ----------------
    pu_state_e  pu_state, pu_state_nxt;
    logic [3:0] dly_cnt, dly_cnt_nxt;
    logic       cap_full;

    // DELAY lasts ACK_DELAY cycles, so ack lands ACK_DELAY+1 cycles after
    // rdy is first sampled; with zero delay WAIT goes straight to ACK.
    always_comb begin
        pu_state_nxt = pu_state;
        dly_cnt_nxt  = dly_cnt;
        unique case (pu_state)
            PU_WAIT: begin
                if (dev_output_rdy) begin
                    if (ACK_DELAY == 0) begin
                        pu_state_nxt = PU_ACK;
                    end else begin
                        pu_state_nxt = PU_DELAY;
                        dly_cnt_nxt  = DLY_LOAD;
                    end
                end
            end
            PU_DELAY: begin
                if (!dev_output_rdy)     pu_state_nxt = PU_WAIT;
                else if (dly_cnt == '0)  pu_state_nxt = PU_ACK;
                else                     dly_cnt_nxt  = dly_cnt - 4'd1;
            end
            default: pu_state_nxt = PU_WAIT;
        endcase
    end

    assign dev_output_ack = (pu_state == PU_ACK);
    // Count saturates at OUT_DEPTH, which is exactly when its top bit sets.
    assign cap_full       = punch_count[OAW];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pu_state    <= PU_WAIT;
            dly_cnt     <= '0;
            punch_count <= '0;
            punch_ovf   <= 1'b0;
        end else begin
            pu_state <= pu_state_nxt;
            dly_cnt  <= dly_cnt_nxt;
            if (dev_output_ack) begin
                if (cap_full) punch_ovf   <= 1'b1;
                else          punch_count <= punch_count + (OAW+1)'(1);
            end
        end
    end

    sim_dev_mem #(.DEPTH(OUT_DEPTH), .W(CODE_W)) u_capture (
        .clk    (clk),
        .resetn (resetn),
        .we     (dev_output_ack && !cap_full),
        .waddr  (punch_count[OAW-1:0]),
        .wdata  (dev_output_data),
        .raddr  (rd_addr),
        .rdata  (rd_data)
    );

endmodule

// File: tb/tb_sim_tape_dev.sv
// Bench for sim_tape_dev: two instances (IN_GAP=1/ACK_DELAY=2 and
// IN_GAP=0/ACK_DELAY=0) share reader stimulus; expected streams come from
// a tape array and per-instance cycle bookkeeping, punch results from a
// capture array model.
module tb_sim_tape_dev;

    localparam int DEPTH = 64;

    logic            clk, resetn;
    logic            ld_we;
    logic [5:0]      ld_addr;
    logic [4:0]      ld_data;
    logic [6:0]      ld_len;
    logic            tape_start;
    logic            in_rdy;
    logic [1:0]      out_rdy;
    logic [4:0]      out_data;
    logic [5:0]      rd_addr;

    logic [1:0]      in_val, out_ack, busy, done, ovf;
    logic [1:0][4:0] in_data, rd_data;
    logic [1:0][6:0] pcount;

    int total, bad;
    int gapv[2];
    int dlyv[2];
    logic [4:0] tape[DEPTH];
    logic [4:0] cap[2][DEPTH];
    int ccount[2];
    bit covf[2];

    sim_tape_dev #(.IN_DEPTH(DEPTH), .OUT_DEPTH(DEPTH), .ACK_DELAY(2), .IN_GAP(1)) u_dut_a (
        .clk(clk), .resetn(resetn), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_len(ld_len), .tape_start(tape_start), .dev_input_val(in_val[0]),
        .dev_input_data(in_data[0]), .dev_input_rdy(in_rdy), .dev_output_rdy(out_rdy[0]),
        .dev_output_data(out_data), .dev_output_ack(out_ack[0]), .rd_addr(rd_addr),
        .rd_data(rd_data[0]), .punch_count(pcount[0]), .reader_busy(busy[0]),
        .reader_done(done[0]), .punch_ovf(ovf[0])
    );

    sim_tape_dev #(.IN_DEPTH(DEPTH), .OUT_DEPTH(DEPTH), .ACK_DELAY(0), .IN_GAP(0)) u_dut_b (
        .clk(clk), .resetn(resetn), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_len(ld_len), .tape_start(tape_start), .dev_input_val(in_val[1]),
        .dev_input_data(in_data[1]), .dev_input_rdy(in_rdy), .dev_output_rdy(out_rdy[1]),
        .dev_output_data(out_data), .dev_output_ack(out_ack[1]), .rd_addr(rd_addr),
        .rd_data(rd_data[1]), .punch_count(pcount[1]), .reader_busy(busy[1]),
        .reader_done(done[1]), .punch_ovf(ovf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input logic [4:0] v);
        ld_we = 1'b1; ld_addr = 6'(a); ld_data = v;
        @(negedge clk);
        ld_we = 1'b0;
        tape[a] = v;
    endtask

    // Streams a pass of 'len' codes; pct is the per-cycle chance rdy is high.
    // When rdy is random, writes and tape_start are also thrown at the busy
    // readers and must have no effect.
    task automatic run_tape(input int len, input int pct);
        int idx[2];
        int nextv[2];
        bit fin[2];
        bit ev, last, quiet;
        int c;
        ld_len = 7'(len); tape_start = 1'b1;
        @(negedge clk);
        tape_start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            idx[d] = 0; nextv[d] = 0; fin[d] = (len == 0);
        end
        last = 1'b0; c = 0;
        while (1) begin
            for (int d = 0; d < 2; d++) begin
                ev = !fin[d] && (c >= nextv[d]);
                chk("in_val", 32'(in_val[d]), 32'(ev));
                if (ev) chk("in_data", 32'(in_data[d]), 32'(tape[idx[d]]));
                chk("busy", 32'(busy[d]), 32'(!fin[d]));
                chk("done", 32'(done[d]), 32'(fin[d]));
            end
            if (last) break;
            if (c > 600) begin
                chk("tape_timeout", 32'(c), 32'(0));
                break;
            end
            ld_we = 1'b0; tape_start = 1'b0;
            in_rdy = ($urandom_range(99) < pct);
            quiet = fin[0] || fin[1];
            if (!quiet && pct < 100) begin
                ld_we = 1'($urandom_range(1));
                ld_addr = 6'($urandom_range(DEPTH-1));
                ld_data = 5'($urandom_range(31));
                tape_start = 1'($urandom_range(1));
            end
            for (int d = 0; d < 2; d++) begin
                if (!fin[d] && c >= nextv[d] && in_rdy) begin
                    idx[d]++;
                    if (idx[d] == len) fin[d] = 1'b1;
                    else nextv[d] = c + 1 + gapv[d];
                end
            end
            if (fin[0] && fin[1]) last = 1'b1;
            c++;
            @(negedge clk);
        end
        ld_we = 1'b0; tape_start = 1'b0; in_rdy = 1'b0;
    endtask

    task automatic punch(input int d, input logic [4:0] v);
        int n;
        out_data = v; out_rdy[d] = 1'b1; n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_ack[d] && n < 20);
        chk("ack_latency", 32'(n), 32'(dlyv[d] + 1));
        out_rdy[d] = 1'b0;
        @(negedge clk);
        chk("ack_single", 32'(out_ack[d]), 32'(0));
        if (ccount[d] < DEPTH) begin
            cap[d][ccount[d]] = v;
            ccount[d]++;
        end else begin
            covf[d] = 1'b1;
        end
        chk("punch_count", 32'(pcount[d]), 32'(ccount[d]));
        chk("punch_ovf", 32'(ovf[d]), 32'(covf[d]));
    endtask

    task automatic readback(input int n);
        for (int a = 0; a < n; a++) begin
            rd_addr = 6'(a);
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                if (a < ccount[d]) chk("rd_data", 32'(rd_data[d]), 32'(cap[d][a]));
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < DEPTH; a++) load(a, 5'($urandom_range(31)));
    endtask

    initial begin
        total = 0; bad = 0;
        gapv[0] = 1; gapv[1] = 0;
        dlyv[0] = 2; dlyv[1] = 0;
        ccount[0] = 0; ccount[1] = 0; covf[0] = 1'b0; covf[1] = 1'b0;
        resetn = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0; ld_len = '0;
        tape_start = 1'b0; in_rdy = 1'b0; out_rdy = '0; out_data = '0; rd_addr = '0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_val", 32'(in_val[d]), 32'(0));
            chk("rst_data", 32'(in_data[d]), 32'(0));
            chk("rst_ack", 32'(out_ack[d]), 32'(0));
            chk("rst_rd_data", 32'(rd_data[d]), 32'(0));
            chk("rst_count", 32'(pcount[d]), 32'(0));
            chk("rst_flags", 32'({busy[d], done[d], ovf[d]}), 32'(0));
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Directed 3-code tape, then empty tape.
        load(0, 5'd3); load(1, 5'd17); load(2, 5'd31);
        run_tape(3, 100);
        run_tape(0, 100);

        // Random tapes with full and intermittent rdy, including full length.
        fill_random();
        run_tape(int'($urandom_range(1, 20)), 100);
        for (int i = 0; i < 4; i++) run_tape(int'($urandom_range(1, 20)), 50);
        run_tape(DEPTH, 70);
        run_tape(1, 30);

        // Punch: fixed code, aborted request, random codes, readback.
        punch(0, 5'h15);
        punch(1, 5'h15);
        readback(1);
        out_data = 5'h0a; out_rdy[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("abort_ack", 32'(out_ack[0]), 32'(0));
        end
        out_rdy[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("abort_ack", 32'(out_ack[0]), 32'(0));
        end
        chk("abort_count", 32'(pcount[0]), 32'(ccount[0]));
        for (int i = 0; i < 5; i++) begin
            punch(0, 5'($urandom_range(31)));
            punch(1, 5'($urandom_range(31)));
        end
        readback(ccount[0]);

        // Fill both capture buffers, then overflow twice (sticky).
        for (int d = 0; d < 2; d++) begin
            while (ccount[d] < DEPTH) punch(d, 5'($urandom_range(31)));
            chk("full_ovf", 32'(ovf[d]), 32'(0));
            punch(d, 5'h1f);
            punch(d, 5'h00);
        end
        readback(DEPTH);

        // Asynchronous reset while a code is being offered.
        ld_len = 7'd5; tape_start = 1'b1; in_rdy = 1'b0;
        @(negedge clk);
        tape_start = 1'b0;
        @(negedge clk);
        chk("pre_rst_val", 32'(in_val), 32'(2'b11));
        #2 resetn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("arst_val", 32'(in_val[d]), 32'(0));
            chk("arst_busy", 32'(busy[d]), 32'(0));
            chk("arst_count", 32'(pcount[d]), 32'(0));
            chk("arst_ovf", 32'(ovf[d]), 32'(0));
            chk("arst_rd_data", 32'(rd_data[d]), 32'(0));
            ccount[d] = 0; covf[d] = 1'b0;
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_tape(5, 100);
        punch(0, 5'h07);
        punch(1, 5'h19);
        readback(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
